// File: rtl/fht_stage_ctrl_if.sv
// Control bundle between the FHT top-level control and the stage sequencer.
// The sequencer takes the slave modport; the top-level control (or a bench) takes master.
interface fht_stage_ctrl_if #(
    parameter int A_BIT   = 9,
    parameter int ST_BIT  = 4,
    parameter int SEC_BIT = 9,
    parameter int ROM_BIT = 9
);
    logic               iSTART;
    logic               oBUSY;
    logic               oDONE;
    logic [A_BIT-1:0]   oRD_ADDR;
    logic [A_BIT-1:0]   oWR_ADDR;
    logic               oWR_EN;
    logic [ST_BIT-1:0]  oSTAGE;
    logic               oST_ZERO;
    logic               oST_LAST;
    logic               o2ND_PART_SUBSEC;
    logic [SEC_BIT-1:0] oSECTOR;
    logic [ROM_BIT-1:0] oROM_ADDR;

    modport master (
        output iSTART,
        input  oBUSY, oDONE, oRD_ADDR, oWR_ADDR, oWR_EN, oSTAGE,
               oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR, oROM_ADDR
    );

    modport slave (
        input  iSTART,
        output oBUSY, oDONE, oRD_ADDR, oWR_ADDR, oWR_EN, oSTAGE,
               oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR, oROM_ADDR
    );
endinterface

// File: rtl/fht_stage_ctrl.sv
// FHT stage sequencer: walks every stage over the four banks, generates read/write
// addresses, mixer sector controls and twiddle addresses, draining the butterfly between stages.
module fht_stage_ctrl #(
    parameter int A_BIT    = 9,
    parameter int ST_NUM   = 10,
    parameter int SEC_BIT  = 9,
    parameter int PIPE_LAT = 4,
    parameter int ROM_BIT  = 9
) (
    input logic               iCLK,
    input logic               iRESET,
    fht_stage_ctrl_if.slave   bus
);
    localparam int ST_BIT = $clog2(ST_NUM);
    localparam int DR_BIT = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              state, state_nx;
    logic [ST_BIT-1:0]   stage, stage_nx;
    logic [A_BIT-1:0]    rd_cnt, rd_cnt_nx;
    logic [DR_BIT-1:0]   drn_cnt, drn_cnt_nx;

    // read-valid / address travel alongside the butterfly pipeline
    logic [PIPE_LAT:1]             vld_pipe;
    logic [PIPE_LAT:1][A_BIT-1:0]  addr_pipe;

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state   <= IDLE;
            stage   <= '0;
            rd_cnt  <= '0;
            drn_cnt <= '0;
        end else begin
            state   <= state_nx;
            stage   <= stage_nx;
            rd_cnt  <= rd_cnt_nx;
            drn_cnt <= drn_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        stage_nx   = stage;
        rd_cnt_nx  = rd_cnt;
        drn_cnt_nx = drn_cnt;
        case (state)
            IDLE: begin
                if (bus.iSTART) begin
                    state_nx  = READ;
                    stage_nx  = '0;
                    rd_cnt_nx = '0;
                end
            end
            READ: begin
                rd_cnt_nx = rd_cnt + 1'b1;
                if (&rd_cnt) begin
                    state_nx   = DRAIN;
                    drn_cnt_nx = '0;
                end
            end
            DRAIN: begin
                drn_cnt_nx = drn_cnt + 1'b1;
                if (drn_cnt == DR_BIT'(PIPE_LAT - 1)) begin
                    if (stage == ST_BIT'(ST_NUM - 1)) begin
                        state_nx = DONE;
                    end else begin
                        stage_nx = stage + 1'b1;
                        state_nx = READ;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // reset flushes in-flight writes rather than letting them land
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[1]  <= (state == READ);
            addr_pipe[1] <= rd_cnt;
            for (int i = 2; i <= PIPE_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    // sub-section size grows with the stage and saturates at the bank depth
    int               m;
    logic [A_BIT-1:0] mask, sec_full, rom_full, sh;
    logic             second;

    always_comb begin
        m        = (int'(stage) < A_BIT) ? int'(stage) : A_BIT;
        mask     = A_BIT'((1 << m) - 1);
        sec_full = rd_cnt & mask;
        rom_full = sec_full << (A_BIT - m);
        sh       = '0;
        second   = 1'b0;
        if (m > 0) begin
            sh     = rd_cnt >> (m - 1);
            second = sh[0];
        end
    end

    assign bus.oBUSY            = (state != IDLE);
    assign bus.oDONE            = (state == DONE);
    assign bus.oRD_ADDR         = rd_cnt;
    assign bus.oWR_EN           = vld_pipe[PIPE_LAT];
    assign bus.oWR_ADDR         = addr_pipe[PIPE_LAT];
    assign bus.oSTAGE           = stage;
    assign bus.oST_ZERO         = (stage == '0);
    assign bus.oST_LAST         = (stage == ST_BIT'(ST_NUM - 1));
    assign bus.o2ND_PART_SUBSEC = second;
    assign bus.oSECTOR          = SEC_BIT'(sec_full);
    assign bus.oROM_ADDR        = ROM_BIT'(rom_full);
endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Bench for fht_stage_ctrl: per-cycle expected outputs are queued when a start is
// driven and popped/compared on every falling edge (PIPE_LAT=4 and PIPE_LAT=1 instances).
module tb_fht_stage_ctrl;
    localparam int A   = 3;
    localparam int D   = 1 << A;
    localparam int ST  = 3;
    localparam int STB = $clog2(ST);

    typedef struct {
        int busy, done, rd, wen, wa, stage, stz, stl, sec, sec2, rom;
    } exp_t;

    logic clk, rst_n, mon_en;
    int   n_vec, n_err;
    exp_t q0[$];
    exp_t q1[$];

    fht_stage_ctrl_if #(.A_BIT(A), .ST_BIT(STB), .SEC_BIT(3), .ROM_BIT(3)) bus0 ();
    fht_stage_ctrl_if #(.A_BIT(A), .ST_BIT(STB), .SEC_BIT(3), .ROM_BIT(3)) bus1 ();

    fht_stage_ctrl #(.A_BIT(A), .ST_NUM(ST), .SEC_BIT(3), .PIPE_LAT(4), .ROM_BIT(3))
        dut0 (.iCLK(clk), .iRESET(rst_n), .bus(bus0));
    fht_stage_ctrl #(.A_BIT(A), .ST_NUM(ST), .SEC_BIT(3), .PIPE_LAT(1), .ROM_BIT(3))
        dut1 (.iCLK(clk), .iRESET(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        if (exp >= 0) begin
            n_vec++;
            if (got != exp) begin
                n_err++;
                $display("FAIL %s got %0d exp %0d @%0t", tag, got, exp, $time);
            end
        end
    endtask

    task automatic cmp_all(input string p, input exp_t o, input exp_t e);
        chk({p, "_busy"},  o.busy,  e.busy);
        chk({p, "_done"},  o.done,  e.done);
        chk({p, "_rd"},    o.rd,    e.rd);
        chk({p, "_wen"},   o.wen,   e.wen);
        chk({p, "_wa"},    o.wa,    e.wa);
        chk({p, "_stage"}, o.stage, e.stage);
        chk({p, "_stz"},   o.stz,   e.stz);
        chk({p, "_stl"},   o.stl,   e.stl);
        chk({p, "_sec"},   o.sec,   e.sec);
        chk({p, "_sec2"},  o.sec2,  e.sec2);
        chk({p, "_rom"},   o.rom,   e.rom);
    endtask

    // expected outputs t cycles after the start-sampling edge (t=1 is the first READ)
    function automatic exp_t exp_at(input int t, input int pl);
        exp_t e;
        int per, s, p, tw, m;
        e   = '{default: -1};
        per = D + pl;
        if (t <= ST * per) begin
            s       = (t - 1) / per;
            p       = (t - 1) % per;
            e.busy  = 1;
            e.done  = 0;
            e.stage = s;
            e.stz   = (s == 0) ? 1 : 0;
            e.stl   = (s == ST - 1) ? 1 : 0;
            e.rd    = (p < D) ? p : 0;
            if (p < D) begin
                m      = (s < A) ? s : A;
                e.sec  = p % (1 << m);
                e.sec2 = (s >= 1) ? ((p >> (m - 1)) & 1) : 0;
                e.rom  = e.sec << (A - m);
            end
        end else if (t == ST * per + 1) begin
            e.busy  = 1;
            e.done  = 1;
            e.rd    = 0;
            e.stage = ST - 1;
            e.stz   = 0;
            e.stl   = 1;
        end else begin
            e.busy = 0;
            e.done = 0;
        end
        tw = t - pl;
        if (tw >= 1 && tw <= ST * per && ((tw - 1) % per) < D) begin
            e.wen = 1;
            e.wa  = (tw - 1) % per;
        end else begin
            e.wen = 0;
        end
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e      = '{default: -1};
        e.busy = 0;
        e.done = 0;
        e.wen  = 0;
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e       = idle_exp();
        e.rd    = 0;
        e.stage = 0;
        e.stz   = 1;
        e.stl   = 0;
        e.sec   = 0;
        e.sec2  = 0;
        e.rom   = 0;
        return e;
    endfunction

    function automatic exp_t obs0();
        exp_t o;
        o.busy = int'(bus0.oBUSY);    o.done = int'(bus0.oDONE);
        o.rd   = int'(bus0.oRD_ADDR); o.wen  = int'(bus0.oWR_EN);
        o.wa   = int'(bus0.oWR_ADDR); o.stage = int'(bus0.oSTAGE);
        o.stz  = int'(bus0.oST_ZERO); o.stl  = int'(bus0.oST_LAST);
        o.sec  = int'(bus0.oSECTOR);  o.sec2 = int'(bus0.o2ND_PART_SUBSEC);
        o.rom  = int'(bus0.oROM_ADDR);
        return o;
    endfunction

    function automatic exp_t obs1();
        exp_t o;
        o.busy = int'(bus1.oBUSY);    o.done = int'(bus1.oDONE);
        o.rd   = int'(bus1.oRD_ADDR); o.wen  = int'(bus1.oWR_EN);
        o.wa   = int'(bus1.oWR_ADDR); o.stage = int'(bus1.oSTAGE);
        o.stz  = int'(bus1.oST_ZERO); o.stl  = int'(bus1.oST_LAST);
        o.sec  = int'(bus1.oSECTOR);  o.sec2 = int'(bus1.o2ND_PART_SUBSEC);
        o.rom  = int'(bus1.oROM_ADDR);
        return o;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (q0.size() > 0) cmp_all("d0", obs0(), q0.pop_front());
            else               cmp_all("d0_idle", obs0(), idle_exp());
            if (q1.size() > 0) cmp_all("d1", obs1(), q1.pop_front());
            else               cmp_all("d1_idle", obs1(), idle_exp());
        end
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        bus0.iSTART = 1'b0;
        bus1.iSTART = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_all("d0_rst", obs0(), reset_exp());
        cmp_all("d1_rst", obs1(), reset_exp());
        mon_en = 1'b1;

        // full transform with stray starts at k+5 and on the DONE cycle
        @(posedge clk); #1 bus0.iSTART = 1'b1;
        @(posedge clk); #1 bus0.iSTART = 1'b0;
        for (int t = 1; t <= 38; t++) q0.push_back(exp_at(t, 4));
        repeat (4) @(posedge clk); #1 bus0.iSTART = 1'b1;
        @(posedge clk); #1 bus0.iSTART = 1'b0;
        repeat (31) @(posedge clk); #1 bus0.iSTART = 1'b1;
        // held over the DONE edge (ignored) and the first IDLE edge (accepted)
        @(posedge clk);
        @(posedge clk); #1 bus0.iSTART = 1'b0;

        // restarted transform, aborted by reset mid-DRAIN of stage 0
        for (int t = 1; t <= 10; t++) q0.push_back(exp_at(t, 4));
        for (int i = 0; i < 3; i++) q0.push_back(reset_exp());
        repeat (9) @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);

        // single-cycle pipeline latency instance
        @(posedge clk); #1 bus1.iSTART = 1'b1;
        @(posedge clk); #1 bus1.iSTART = 1'b0;
        for (int t = 1; t <= ST * (D + 1) + 2; t++) q1.push_back(exp_at(t, 1));
        repeat (ST * (D + 1) + 8) @(posedge clk);

        #1;
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fht_stage_ctrl.md
# fht_stage_ctrl

Sequencer for the FHT double-butterfly datapath. On a start pulse it runs every stage of an in-place transform over the four data banks: it generates bank read/write addresses, write enables, stage flags, sector/sub-sector controls for the input and output bank mixers, and twiddle ROM addresses. It sits between the top-level FHT control and the butterfly block plus its bank RAMs, and drains the butterfly pipeline between stages so in-place reads never overtake pending writes.

## Interface
- A_BIT, 9: bank address width; each bank holds DEPTH = 2^A_BIT words (one read per cycle feeds two butterflies).
- ST_NUM, 10: number of stages per transform (≥2).
- SEC_BIT, 9: width of oSECTOR.
- PIPE_LAT, 4: cycles from a bank read address to the matching butterfly-block output (≥1).
- ROM_BIT, 9: twiddle ROM address width.

- iCLK  in  1  clock, all logic on rising edge.
- iRESET  in  1  reset, synchronous, active-low.
- iSTART  in  1  start pulse; honoured only in IDLE.
- oBUSY  out  1  high from first READ cycle through DONE.
- oDONE  out  1  one-cycle pulse in DONE state.
- oRD_ADDR  out  A_BIT  bank read address (all four banks).
- oWR_ADDR  out  A_BIT  bank write address.
- oWR_EN  out  1  bank write enable.
- oSTAGE  out  ceil(log2(ST_NUM))  current stage index.
- oST_ZERO  out  1  stage == 0.
- oST_LAST  out  1  stage == ST_NUM-1.
- o2ND_PART_SUBSEC  out  1  second half of current sub-section.
- oSECTOR  out  SEC_BIT  position within current sub-section.
- oROM_ADDR  out  ROM_BIT  twiddle ROM address.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE. Reset state IDLE.
- IDLE: iSTART=1 → READ, stage=0, rd_cnt=0. iSTART=0 → stay.
- READ: oRD_ADDR=rd_cnt; rd_cnt increments each cycle; at rd_cnt==DEPTH-1 → DRAIN, rd_cnt wraps to 0.
- DRAIN: counts PIPE_LAT cycles; on last one: stage==ST_NUM-1 → DONE, else stage+1 and → READ.
- DONE: one cycle, oDONE=1 → IDLE.
- iSTART in any state other than IDLE is ignored (no queueing).
- Write path: a PIPE_LAT-deep shift register carries (read-valid, rd_cnt); its tail drives oWR_EN and oWR_ADDR. Write of address a occurs exactly PIPE_LAT cycles after its read.
- Derived controls (combinational from registered stage/rd_cnt, valid in READ; held during DRAIN since stage is frozen until DRAIN ends):
  - s = stage; m = min(s, A_BIT).
  - oSECTOR = rd_cnt mod 2^m, zero-extended/truncated to SEC_BIT.
  - o2ND_PART_SUBSEC = rd_cnt[m-1] for s≥1, 0 for s=0.
  - oROM_ADDR = (rd_cnt mod 2^m) << (A_BIT - m), truncated to ROM_BIT.
  - oST_ZERO, oST_LAST decode oSTAGE; stable for whole stage including DRAIN.
- All outputs registered or decoded from registers; no combinational path from iSTART to outputs.

## Timing
- Reset (iRESET=0 at an edge): next cycle state IDLE, stage=0, rd_cnt=0, write pipeline cleared; all outputs 0 except oST_ZERO=1 (stage 0). Reset mid-transform aborts immediately; pending writes are dropped, not completed.
- iSTART sampled at edge k in IDLE: READ from cycle k+1, oRD_ADDR=0 at k+1, oBUSY=1 at k+1.
- Per stage: DEPTH READ cycles + PIPE_LAT DRAIN cycles; no idle cycle between DRAIN and next READ.
- Last write of each stage lands in the final DRAIN cycle; first read of next stage is the following cycle (no RAW hazard).
- oDONE at cycle k + ST_NUM·(DEPTH+PIPE_LAT) + 1; oBUSY falls the cycle after.
- iSTART on the DONE cycle is ignored; a new start is accepted from the first IDLE cycle.

## Test plan
- A_BIT=3, ST_NUM=3, PIPE_LAT=4; iSTART at edge k → oRD_ADDR 0..7 on k+1..k+8, oWR_EN high k+5..k+12 with oWR_ADDR 0..7, stage 1 reads start k+13, oDONE single pulse at k+37, oBUSY high k+1..k+37.
- Same config, stage 2 (oST_LAST=1): oSECTOR sequence 0,1,2,3,0,1,2,3; o2ND_PART_SUBSEC 0,0,1,1,0,0,1,1; oROM_ADDR 0,2,4,6,0,2,4,6 (ROM_BIT=3).
- Stage 0: oST_ZERO=1, oSECTOR=0, o2ND_PART_SUBSEC=0, oROM_ADDR=0 on every READ cycle; stage 1: o2ND_PART_SUBSEC 0,1,0,1,….
- iSTART pulsed at k+5 and on the oDONE cycle → no restart, no timing change; pulse at k+38 → new transform, oRD_ADDR=0 at k+39.
- iRESET=0 for one edge at k+10 (mid-DRAIN) → next cycle IDLE, oWR_EN=0, oBUSY=0, oSTAGE=0, oST_ZERO=1; no further writes.
- PIPE_LAT=1: oWR_EN exactly one cycle after each read, DRAIN one cycle, oDONE at k+3·9+1.
